// File: rtl/pipe_ctrl_if.sv
// Pipeline-control bus: decode/execute/memory hazard inputs, branch/halt controls.
// Latency: n/a (wire bundle); the slave side adds its own timing.
// Backpressure: none carried here; stall/halt/bubble/flush are the pipeline's hold controls.
// Ports: slave = pipe_ctrl (hazard inputs in, control outputs out); master = driver of the pipeline side.
interface pipe_ctrl_if #(
  parameter int N_param = 32
);
  logic               dec_valid_i;
  logic [4:0]         dec_rs1_i;
  logic [4:0]         dec_rs2_i;
  logic               dec_use_rs1_i;
  logic               dec_use_rs2_i;
  logic               dec_halt_i;
  logic               ex_valid_i;
  logic [4:0]         ex_rd_i;
  logic               ex_we_i;
  logic               ex_load_i;
  logic               mem_valid_i;
  logic [4:0]         mem_rd_i;
  logic               mem_we_i;
  logic               br_taken_i;
  logic [N_param-1:0] br_target_i;
  logic               resume_i;
  logic               halt_o;
  logic               stall_o;
  logic               bubble_o;
  logic               flush_o;
  logic               isTakenBranch_o;
  logic [N_param-1:0] targetPC_o;
  logic [1:0]         fwd1_sel_o;
  logic [1:0]         fwd2_sel_o;
  logic               halted_o;
  logic [15:0]        stall_cnt_o;

  modport slave (
    input  dec_valid_i, dec_rs1_i, dec_rs2_i, dec_use_rs1_i, dec_use_rs2_i, dec_halt_i,
    input  ex_valid_i, ex_rd_i, ex_we_i, ex_load_i,
    input  mem_valid_i, mem_rd_i, mem_we_i,
    input  br_taken_i, br_target_i, resume_i,
    output halt_o, stall_o, bubble_o, flush_o, isTakenBranch_o, targetPC_o,
    output fwd1_sel_o, fwd2_sel_o, halted_o, stall_cnt_o
  );

  modport master (
    output dec_valid_i, dec_rs1_i, dec_rs2_i, dec_use_rs1_i, dec_use_rs2_i, dec_halt_i,
    output ex_valid_i, ex_rd_i, ex_we_i, ex_load_i,
    output mem_valid_i, mem_rd_i, mem_we_i,
    output br_taken_i, br_target_i, resume_i,
    input  halt_o, stall_o, bubble_o, flush_o, isTakenBranch_o, targetPC_o,
    input  fwd1_sel_o, fwd2_sel_o, halted_o, stall_cnt_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline control: load-use stall, forwarding selects, branch flush, ecall/ebreak drain+halt.
// Latency: stall/bubble/fwd combinational; branch redirect and flush start one cycle after br_taken_i.
// Backpressure: stall_o/halt_o hold fetch+decode, bubble_o squashes execute, flush_o clears both.
// Ports: clk, reset (async active-low), bus (pipe_ctrl_if.slave): hazard inputs in, pipeline controls out.
module pipe_ctrl #(
  parameter int N_param      = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic       clk,
  input  logic       reset,
  pipe_ctrl_if.slave bus
);
  typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1, DRAIN = 2'd2, HALTED = 2'd3} state_t;

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   seq_cnt_q, seq_cnt_d;   // cycles left in FLUSH or DRAIN, minus one
  logic               taken_q;
  logic [N_param-1:0] target_q;
  logic [15:0]        stall_cnt_q;

  logic ex_hit1, ex_hit2, mem_hit1, mem_hit2, luse;
  logic br_accept, run_free, stall_hit, halt_req;
  logic halt_c, stall_c, bubble_c, flush_c, halted_c;
  logic [1:0] fwd1_c, fwd2_c;

  assign ex_hit1  = bus.ex_valid_i & bus.ex_we_i & (bus.ex_rd_i != 5'd0)
                  & bus.dec_use_rs1_i & (bus.dec_rs1_i == bus.ex_rd_i);
  assign ex_hit2  = bus.ex_valid_i & bus.ex_we_i & (bus.ex_rd_i != 5'd0)
                  & bus.dec_use_rs2_i & (bus.dec_rs2_i == bus.ex_rd_i);
  assign mem_hit1 = bus.mem_valid_i & bus.mem_we_i & (bus.mem_rd_i != 5'd0)
                  & bus.dec_use_rs1_i & (bus.dec_rs1_i == bus.mem_rd_i);
  assign mem_hit2 = bus.mem_valid_i & bus.mem_we_i & (bus.mem_rd_i != 5'd0)
                  & bus.dec_use_rs2_i & (bus.dec_rs2_i == bus.mem_rd_i);

  assign luse = bus.dec_valid_i & bus.ex_load_i & (ex_hit1 | ex_hit2);

  // Branches are only architectural in RUN and DRAIN; in FLUSH they are wrong-path.
  assign br_accept = bus.br_taken_i & ((state_q == RUN) | (state_q == DRAIN));
  assign run_free  = (state_q == RUN) & ~bus.br_taken_i;
  assign stall_hit = run_free & luse;
  // A stalled ecall stays in decode and is re-presented, so halt entry waits for the stall to clear.
  assign halt_req  = run_free & ~luse & bus.dec_valid_i & bus.dec_halt_i;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= RUN;
      seq_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      seq_cnt_q <= seq_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    seq_cnt_d = seq_cnt_q;
    case (state_q)
      RUN: begin
        if (bus.br_taken_i) begin
          state_d   = FLUSH;
          seq_cnt_d = FLUSH_LAST;
        end else if (halt_req) begin
          state_d   = DRAIN;
          seq_cnt_d = DRAIN_LAST;
        end
      end
      FLUSH: begin
        if (seq_cnt_q == '0) state_d = RUN;
        else                 seq_cnt_d = seq_cnt_q - 1'b1;
      end
      DRAIN: begin
        if (bus.br_taken_i) begin
          state_d   = FLUSH;
          seq_cnt_d = FLUSH_LAST;
        end else if (seq_cnt_q == '0) begin
          state_d = HALTED;
        end else begin
          seq_cnt_d = seq_cnt_q - 1'b1;
        end
      end
      HALTED: begin
        if (bus.resume_i) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Output logic; every combinational output is forced low while reset is held.
  always_comb begin
    halt_c   = 1'b0;
    stall_c  = 1'b0;
    bubble_c = 1'b0;
    flush_c  = 1'b0;
    halted_c = 1'b0;
    fwd1_c   = 2'b00;
    fwd2_c   = 2'b00;
    if (reset) begin
      // A load's data is not ready in execute, so it can only forward from memory.
      if (ex_hit1 & ~bus.ex_load_i) fwd1_c = 2'b01;
      else if (mem_hit1)            fwd1_c = 2'b10;
      if (ex_hit2 & ~bus.ex_load_i) fwd2_c = 2'b01;
      else if (mem_hit2)            fwd2_c = 2'b10;
      case (state_q)
        RUN: begin
          stall_c  = stall_hit;
          halt_c   = stall_hit;
          bubble_c = stall_hit;
        end
        FLUSH: flush_c = 1'b1;
        DRAIN: begin
          halt_c   = 1'b1;
          bubble_c = 1'b1;
        end
        HALTED: begin
          halt_c   = 1'b1;
          bubble_c = 1'b1;
          halted_c = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Redirect pulse, held target and saturating stall counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      taken_q     <= 1'b0;
      target_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      taken_q <= br_accept;
      if (br_accept) target_q <= bus.br_target_i;
      if (stall_hit && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign bus.halt_o          = halt_c;
  assign bus.stall_o         = stall_c;
  assign bus.bubble_o        = bubble_c;
  assign bus.flush_o         = flush_c;
  assign bus.halted_o        = halted_c;
  assign bus.fwd1_sel_o      = fwd1_c;
  assign bus.fwd2_sel_o      = fwd2_c;
  assign bus.isTakenBranch_o = taken_q;
  assign bus.targetPC_o      = target_q;
  assign bus.stall_cnt_o     = stall_cnt_q;
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Pipeline control unit for the riscv32i core. It sequences the fetch/decode/execute/memory pipeline registers and drives the pc block's halt and branch-redirect inputs. It detects load-use hazards, generates operand-forwarding selects, and flushes wrong-path instructions on taken branches. It also drains and halts the core on ecall/ebreak, resuming on request.

Parameters:
N_param, 32, datapath/PC width
FLUSH_CYCLES, 2, cycles flush_o stays high after a taken branch (younger stages to squash)
DRAIN_CYCLES, 3, cycles needed to retire in-flight instructions before entering HALTED

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-low reset
dec_valid_i  in  1  decode stage holds a valid instruction
dec_rs1_i  in  5  decode source register 1
dec_rs2_i  in  5  decode source register 2
dec_use_rs1_i  in  1  decode instruction reads rs1
dec_use_rs2_i  in  1  decode instruction reads rs2
dec_halt_i  in  1  decode instruction is ecall/ebreak
ex_valid_i  in  1  execute stage valid
ex_rd_i  in  5  execute destination register
ex_we_i  in  1  execute instruction writes rd
ex_load_i  in  1  execute instruction is a load
mem_valid_i  in  1  memory stage valid
mem_rd_i  in  5  memory destination register
mem_we_i  in  1  memory instruction writes rd
br_taken_i  in  1  execute resolved a taken branch/jump this cycle
br_target_i  in  N_param  resolved target PC
resume_i  in  1  leave HALTED
halt_o  out  1  to pc halt_i: hold PC
stall_o  out  1  hold pipeReg0 contents
bubble_o  out  1  load zero into pipeReg1
flush_o  out  1  zero pipeReg0 and pipeReg1
isTakenBranch_o  out  1  to pc isTakenBranch_i
targetPC_o  out  N_param  to pc targetPC_i
fwd1_sel_o  out  2  operand1 source: 00 regfile, 01 ex result, 10 mem result
fwd2_sel_o  out  2  operand2 source, same encoding
halted_o  out  1  core is in HALTED
stall_cnt_o  out  16  load-use stall cycle counter

Behaviour:
- Reset (reset=0, asynchronous): state RUN, flush counter 0, drain counter 0, stall_cnt_o 0, isTakenBranch_o 0, targetPC_o 0. All combinational outputs evaluate to 0 while in reset.
- States: RUN, FLUSH, DRAIN, HALTED.
- Hit definitions:
  - exhit1 = ex_valid_i & ex_we_i & ex_rd_i!=0 & dec_use_rs1_i & dec_rs1_i==ex_rd_i.
  - memhit1 is defined the same way using the mem_* inputs.
  - rs2 hits are analogous.
- Forwarding (combinational, every state):
  - fwd1_sel_o = 01 if exhit1 & !ex_load_i.
  - Otherwise 10 if memhit1.
  - Otherwise 00.
  - Execute has priority over memory. fwd2_sel_o is analogous.
- Load-use hazard (combinational): luse = dec_valid_i & ex_load_i & (exhit1|exhit2).
  - In RUN with br_taken_i=0, luse drives stall_o=halt_o=bubble_o=1 for that cycle.
  - One bubble suffices, because the load then sits in mem and forwards via 10.
- Branch: br_taken_i=1 in RUN or DRAIN at cycle t produces the following.
  - Cycle t+1: isTakenBranch_o=1 for exactly one cycle, targetPC_o=br_target_i (registered).
  - flush_o=1 for cycles t+1 through t+FLUSH_CYCLES. State is FLUSH during that window, then RUN.
  - Branch beats load-use in the same cycle: no stall, no stall count.
  - In FLUSH: br_taken_i is ignored (wrong path), luse is suppressed, and dec_halt_i is ignored.
- Halt entry: dec_valid_i & dec_halt_i in RUN with br_taken_i=0 moves the state to DRAIN next cycle.
  - DRAIN: halt_o=1 and bubble_o=1 every cycle for DRAIN_CYCLES cycles, then HALTED.
  - br_taken_i during DRAIN aborts the drain and enters FLUSH as above; the halt was wrong-path.
- HALTED: halt_o=1, halted_o=1, bubble_o=1.
  - resume_i=1 returns to RUN next cycle, with halt_o=0 from that cycle.
  - resume_i is ignored in all other states.
- stall_cnt_o: +1 on every cycle where a load-use stall is asserted. Saturates at 0xFFFF and never wraps.
- targetPC_o holds its last value when isTakenBranch_o=0.
- Reset asserted mid-FLUSH or mid-DRAIN returns to RUN immediately; counters clear.

Test Plan:
- Load-use: ex lw x5 (ex_load_i=1, ex_rd_i=5, ex_we_i=1), decode add with rs1=5 -> stall_o=halt_o=bubble_o=1 for exactly 1 cycle. Next cycle, with x5 in mem, fwd1_sel_o=10 and stall_cnt_o=1.
- Forwarding priority: ex_rd=7 (non-load), mem_rd=7, dec rs2=7 -> fwd2_sel_o=01. Same case with rd=0 -> 00. Same case with dec_use_rs2_i=0 -> 00.
- Taken branch: br_taken_i=1, br_target_i=0x00000040 at cycle t -> isTakenBranch_o=1 and targetPC_o=0x40 at t+1 only. flush_o high at t+1 and t+2; second br_taken_i at t+1 ignored.
- Branch vs load-use same cycle: luse conditions true and br_taken_i=1 -> stall_o=0, stall_cnt_o unchanged, flush sequence runs.
- Halt: dec_halt_i=1 in RUN -> halt_o=1 for 3 DRAIN cycles, then halted_o=1. resume_i=1 -> RUN next cycle, halt_o=0. br_taken_i in drain cycle 2 -> FLUSH, halted_o never set.
- Async reset: drop reset mid-FLUSH -> all outputs 0 without a clock edge; stall counter driven to 0xFFFF+1 stalls reads 0xFFFF.
